// File: rtl/dutmem_arbiter.sv
// Round-robin arbiter that shares one single-port memory between NREQ requesters.
// It issues registered memory commands and returns read data with a per-requester valid pulse.
module dutmem_arbiter #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10,
  parameter int NREQ   = 3,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*AWIDTH-1:0]   req_addr,
  input  logic [NREQ*DWIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DWIDTH-1:0]        rdata,
  output logic                     mem_ce,
  output logic                     mem_we,
  output logic [AWIDTH-1:0]        mem_addr,
  output logic [DWIDTH-1:0]        mem_din,
  input  logic [DWIDTH-1:0]        mem_dout
);

  localparam int IW = (NREQ <= 2) ? 1 : $clog2(NREQ);

  logic [IW-1:0]   last;
  logic [IW-1:0]   win;
  logic            win_vld;
  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] elig;

  // A requester granted last cycle is masked so a still-held req is not accepted twice.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise
    // paths that skip an assignment infer a latch.
    elig    = req & ~gnt;
    win_vld = 1'b0;
    win     = '0;
    win_oh  = '0;
    // Indices at or below last form the wrap-around tail; indices above last
    // override them. Descending loops leave the lowest index of each group.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i] && (i <= int'(last))) begin
        win_vld = 1'b1;
        win     = IW'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i] && (i > int'(last))) begin
        win_vld = 1'b1;
        win     = IW'(i);
      end
    end
    if (win_vld) win_oh[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rstn) begin
      gnt      <= '0;
      mem_ce   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      last     <= IW'(NREQ - 1);
    end else if (win_vld) begin
      gnt      <= win_oh;
      mem_ce   <= 1'b1;
      mem_we   <= req_we[win];
      mem_addr <= req_addr[win*AWIDTH +: AWIDTH];
      mem_din  <= req_wdata[win*DWIDTH +: DWIDTH];
      last     <= win;
    end else begin
      gnt    <= '0;
      mem_ce <= 1'b0;
      mem_we <= 1'b0;
    end
  end

  // Read tracker: each stage holds the one-hot owner of a read in flight (all
  // zero for a write or an idle slot). Stage 0 is loaded as the memory samples.
  logic [NREQ-1:0] rd_pipe [RD_LAT];

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: this small array is reset on purpose; clearing it is what discards
    // in-flight reads. Large data memories are normally left unreset.
    if (!rstn) begin
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
    end else begin
      rd_pipe[0] <= (mem_ce && !mem_we) ? gnt : '0;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign rvalid = rd_pipe[RD_LAT-1];
  assign rdata  = mem_dout;

endmodule

// File: tb/tb_dutmem_arbiter.sv
// Bench for dutmem_arbiter: RD_LAT=1 and RD_LAT=3 instances share stimulus and are
// checked every cycle against a transaction-level model of grants, memory and returns.
module tb_dutmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int N  = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt_a, rv_a, gnt_b, rv_b;
  logic [DW-1:0]   rdata_a, rdata_b, din_a, din_b, dout_a, dout_b;
  logic            ce_a, we_a, ce_b, we_b;
  logic [AW-1:0]   addr_a, addr_b;

  dutmem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .NREQ(N), .RD_LAT(1)) dut_a (
    .clk(clk), .rstn(rstn), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt_a), .rvalid(rv_a), .rdata(rdata_a),
    .mem_ce(ce_a), .mem_we(we_a), .mem_addr(addr_a), .mem_din(din_a), .mem_dout(dout_a));

  dutmem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .NREQ(N), .RD_LAT(3)) dut_b (
    .clk(clk), .rstn(rstn), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt_b), .rvalid(rv_b), .rdata(rdata_b),
    .mem_ce(ce_b), .mem_we(we_b), .mem_addr(addr_b), .mem_din(din_b), .mem_dout(dout_b));

  // Memories behind each instance: latency 1 and latency 3 from the command edge.
  logic [DW-1:0] mem_a [1024];
  logic [DW-1:0] mem_b [1024];
  logic [DW-1:0] pipe_b [3];

  always @(posedge clk) begin
    if (ce_a) begin
      if (we_a) mem_a[addr_a] <= din_a;
      else      dout_a <= mem_a[addr_a];
    end
    if (ce_b && we_b) mem_b[addr_b] <= din_b;
    pipe_b[0] <= mem_b[addr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign dout_b = pipe_b[2];

  // Requester-side command registers.
  bit   [N-1:0]  pend, p_we;
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_data [N];

  always_comb begin
    req       = pend;
    req_we    = p_we;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = p_addr[i];
      req_wdata[i*DW +: DW] = p_data[i];
    end
  end

  // Reference model state.
  int            m_last;
  bit   [N-1:0]  m_gnt;
  bit            m_ce, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [DW-1:0] shadow [1024];
  bit   [N-1:0]  rva_q [8];
  bit   [N-1:0]  rvb_q [8];
  logic [DW-1:0] rda_q [8];
  logic [DW-1:0] rdb_q [8];
  int            cyc;
  int            total, bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_last = N - 1;
    m_gnt  = '0;
    m_ce   = 1'b0;
    m_we   = 1'b0;
    m_addr = '0;
    m_din  = '0;
    for (int i = 0; i < 8; i++) begin
      rva_q[i] = '0;
      rvb_q[i] = '0;
      rda_q[i] = '0;
      rdb_q[i] = '0;
    end
    pend = '0;
    p_we = '0;
  endtask

  task automatic issue(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[i]   = 1'b1;
    p_we[i]   = we;
    p_addr[i] = a;
    p_data[i] = d;
  endtask

  // One clock: predict from the pre-edge inputs, then compare every output.
  task automatic tick();
    bit [N-1:0]    elig;
    bit [N-1:0]    e_rva, e_rvb;
    logic [DW-1:0] e_rda, e_rdb;
    int            w, c, s;
    bit            w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    elig = req & ~m_gnt;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      c = (m_last + k) % N;
      if (w < 0 && elig[c]) w = c;
    end
    if (w >= 0) begin
      w_we = p_we[w]; w_addr = p_addr[w]; w_data = p_data[w];
    end else begin
      w_we = 1'b0; w_addr = '0; w_data = '0;
    end
    @(posedge clk);
    #1;
    cyc++;
    s = cyc % 8;
    e_rva = rva_q[s]; e_rda = rda_q[s]; rva_q[s] = '0;
    e_rvb = rvb_q[s]; e_rdb = rdb_q[s]; rvb_q[s] = '0;
    if (w >= 0) begin
      m_gnt  = N'(1) << w;
      m_ce   = 1'b1;
      m_we   = w_we;
      m_addr = w_addr;
      m_din  = w_data;
      m_last = w;
      if (w_we) shadow[w_addr] = w_data;
      else begin
        rva_q[(cyc + 1) % 8] = m_gnt; rda_q[(cyc + 1) % 8] = shadow[w_addr];
        rvb_q[(cyc + 3) % 8] = m_gnt; rdb_q[(cyc + 3) % 8] = shadow[w_addr];
      end
    end else begin
      m_gnt = '0;
      m_ce  = 1'b0;
      m_we  = 1'b0;
    end
    check("gnt_a", gnt_a, m_gnt);
    check("gnt_b", gnt_b, m_gnt);
    check("ce_a", ce_a, m_ce);
    check("we_a", we_a, m_we);
    check("ce_b", ce_b, m_ce);
    check("addr_a", addr_a, m_addr);
    check("din_a", din_a, m_din);
    check("addr_b", addr_b, m_addr);
    check("rvalid_a", rv_a, e_rva);
    check("rvalid_b", rv_b, e_rvb);
    if (e_rva != '0) check("rdata_a", rdata_a, e_rda);
    if (e_rvb != '0) check("rdata_b", rdata_b, e_rdb);
    for (int i = 0; i < N; i++) if (m_gnt[i]) pend[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, {gnt_a, gnt_b}, '0);
    check({tag, "_rv"}, {rv_a, rv_b}, '0);
    check({tag, "_ce_we"}, {ce_a, we_a, ce_b, we_b}, '0);
    check({tag, "_addr"}, {addr_a, addr_b}, '0);
    check({tag, "_din"}, {din_a, din_b}, '0);
  endtask

  int ng, rep;
  logic [N-1:0] prev_g;

  initial begin
    total = 0; bad = 0; cyc = 0;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i]  = 32'(i) * 32'h9E37_79B1;
      mem_b[i]  = mem_a[i];
      shadow[i] = mem_a[i];
    end
    mem_a[5] = 32'hCAFE_0001; mem_b[5] = 32'hCAFE_0001; shadow[5] = 32'hCAFE_0001;
    for (int i = 0; i < N; i++) begin
      p_addr[i] = '0;
      p_data[i] = '0;
    end
    model_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstn = 1'b1;

    // All three read at once: requester 0 first after reset, then 1, then 2.
    issue(0, 0, 10'd1, '0); issue(1, 0, 10'd2, '0); issue(2, 0, 10'd3, '0);
    tick(); check("sim_g0", gnt_a, 3'b001);
    tick(); check("sim_g1", gnt_a, 3'b010); check("sim_rv0", rv_a, 3'b001);
    tick(); check("sim_g2", gnt_a, 3'b100); check("sim_rv1", rv_a, 3'b010);
    tick(); check("sim_rv2", rv_a, 3'b100);
    idle(3);

    // Single read from requester 1 of the preloaded word.
    issue(1, 0, 10'h005, '0);
    tick();
    check("sr_gnt", gnt_a, 3'b010);
    check("sr_cmd", {ce_a, we_a, addr_a}, {1'b1, 1'b0, 10'h005});
    tick();
    check("sr_rv", rv_a, 3'b010);
    check("sr_rdata", rdata_a, 32'hCAFE_0001);
    idle(3);

    // Requesters 0 and 2 held continuously: alternation with no idle cycles.
    ng = 0; rep = 0; prev_g = '0;
    for (int k = 0; k < 6; k++) begin
      if (!pend[0]) issue(0, 0, 10'(16 + k), '0);
      if (!pend[2]) issue(2, 0, 10'(32 + k), '0);
      tick();
      if (gnt_a != '0) ng++;
      if (gnt_a != '0 && gnt_a == prev_g) rep++;
      prev_g = gnt_a;
    end
    check("rot_busy", ng, 6);
    check("rot_repeat", rep, 0);
    pend = '0;
    idle(4);

    // Write from requester 0 to the top address, then read it back on requester 2.
    issue(0, 1, 10'h3FF, 32'h1234_5678);
    tick();
    check("wr_we", {ce_a, we_a, gnt_a}, {1'b1, 1'b1, 3'b001});
    issue(2, 0, 10'h3FF, '0);
    tick();
    check("wr_norv", rv_a, 3'b000);
    tick();
    check("wr_rv", rv_a, 3'b100);
    check("wr_rdata", rdata_a, 32'h1234_5678);
    idle(4);

    // Latency-3 instance: reads on 1, then back-to-back on 2 and 0.
    issue(1, 0, 10'd40, '0);
    tick();
    issue(2, 0, 10'd41, '0); issue(0, 0, 10'd42, '0);
    tick(); tick(); tick();
    check("lat3_rv0", rv_b, 3'b010);
    tick();
    check("lat3_rv1", rv_b, 3'b100);
    tick();
    check("lat3_rv2", rv_b, 3'b001);
    idle(3);

    // Reset while a read is in flight: outputs clear at once, the read never returns.
    issue(1, 0, 10'd7, '0);
    tick();
    #2 rstn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    idle(4);
    issue(0, 0, 10'd8, '0); issue(1, 0, 10'd9, '0); issue(2, 0, 10'd10, '0);
    tick();
    check("post_rst_first", gnt_a, 3'b001);
    idle(4);

    // Random traffic with address reuse so reads observe earlier writes.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 45)
          issue(i, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15)),
                $urandom);
      end
      tick();
    end
    pend = '0;
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
